// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing with clock-enable pixel divider, registered
//            sync/colour outputs lagging drawX/drawY by one pixel period.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pixel_color,
  output logic [10:0] drawX,
  output logic [10:0] drawY,
  output logic        pixel_tick,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [10:0] C_H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] C_H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] C_V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] C_HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] C_VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             frame_q, frame_d;
  logic [10:0]      hc_q, hc_d;
  logic [10:0]      vc_q, vc_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             w_hsync_c, w_vsync_c, w_active_c;

  always_comb begin
    w_hsync_c  = !((hc_q >= C_HS_START) && (hc_q < C_HS_END));
    w_vsync_c  = !((vc_q >= C_VS_START) && (vc_q < C_VS_END));
    w_active_c = (hc_q < C_H_ACT) && (vc_q < C_V_ACT);
  end

  // The tick flop is loaded one clk early so it is high exactly while div_q == CLK_DIV-1.
  always_comb begin
    div_d   = (div_q == C_DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d  = (div_d == C_DIV_LAST);
    hc_d    = hc_q;
    vc_d    = vc_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    frame_d = tick_q && (hc_q == C_H_LAST) && (vc_q == C_V_LAST);
    if (tick_q) begin
      hc_d    = (hc_q == C_H_LAST) ? 11'd0 : hc_q + 11'd1;
      if (hc_q == C_H_LAST) begin
        vc_d  = (vc_q == C_V_LAST) ? 11'd0 : vc_q + 11'd1;
      end
      hsync_d = w_hsync_c;
      vsync_d = w_vsync_c;
      rgb_d   = w_active_c ? pixel_color : 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
      hc_q    <= 11'd0;
      vc_q    <= 11'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 12'h000;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign drawX       = hc_q;
  assign drawY       = vc_q;
  assign pixel_tick  = tick_q;
  assign frame_start = frame_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Randomized colour stimulus against a clock-count raster model.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

  localparam int D  = 4;
  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] pixel_color = 12'h000;
  logic [10:0] drawX, drawY;
  logic        pixel_tick, frame_start, hsync, vsync;
  logic [3:0]  vga_r, vga_g, vga_b;

  int n_checks = 0;
  int n_fail   = 0;
  int e;                 // clk edges since reset release
  logic [11:0] tick_col; // colour present at the most recent tick

  vga_timing_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pixel_color(pixel_color),
    .drawX(drawX), .drawY(drawY), .pixel_tick(pixel_tick),
    .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk_val({pfx, "_x"},     int'(drawX), 0);
    chk_val({pfx, "_y"},     int'(drawY), 0);
    chk_val({pfx, "_tick"},  int'(pixel_tick), 0);
    chk_val({pfx, "_frame"}, int'(frame_start), 0);
    chk_val({pfx, "_hs"},    int'(hsync), 1);
    chk_val({pfx, "_vs"},    int'(vsync), 1);
    chk_val({pfx, "_rgb"},   int'({vga_r, vga_g, vga_b}), 0);
  endtask

  // Expected outputs derived purely from elapsed clocks since reset release.
  task automatic check_model();
    int t, p, x, y, px, py, ex_hs, ex_vs, ex_rgb, ex_fs;
    t  = e / D;
    p  = t % (HT * VT);
    x  = p % HT;
    y  = p / HT;
    ex_fs = (t > 0 && (e % D) == 0 && p == 0) ? 1 : 0;
    if (t == 0) begin
      ex_hs = 1; ex_vs = 1; ex_rgb = 0;
    end else begin
      px = (t - 1) % (HT * VT) % HT;
      py = (t - 1) % (HT * VT) / HT;
      ex_hs  = (px >= HA + HF && px < HA + HF + HS) ? 0 : 1;
      ex_vs  = (py >= VA + VF && py < VA + VF + VS) ? 0 : 1;
      ex_rgb = (px < HA && py < VA) ? int'(tick_col) : 0;
    end
    chk_val("drawX",       int'(drawX), x);
    chk_val("drawY",       int'(drawY), y);
    chk_val("pixel_tick",  int'(pixel_tick), ((e % D) == D - 1) ? 1 : 0);
    chk_val("frame_start", int'(frame_start), ex_fs);
    chk_val("hsync",       int'(hsync), ex_hs);
    chk_val("vsync",       int'(vsync), ex_vs);
    chk_val("rgb",         int'({vga_r, vga_g, vga_b}), ex_rgb);
  endtask

  task automatic run_clks(input int n);
    for (int i = 0; i < n; i++) begin
      check_model();
      pixel_color = ($urandom_range(0, 3) == 0) ? 12'hFA5 : 12'($urandom);
      if ((e % D) == D - 1) tick_col = pixel_color;
      @(posedge clk);
      e++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("held_rst");
    rst_n    = 1'b1;
    e        = 0;
    tick_col = 12'h000;
  endtask

  initial begin
    e        = 0;
    tick_col = 12'h000;
    do_reset();
    run_clks(HT * VT * D * 2 + 777);
    do_reset();
    run_clks(HT * VT * D * 2 + 50);
    do_reset();
    run_clks(HT * VT * D + 20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
